rgb_to_ycbcr_stream: RTL

- Pipelined BT.601 studio-swing RGB → YCbCr colour-space converter with valid/ready streaming handshake.
- Sits on the input side of the upsampling datapath, ahead of the upsampling core.
- Mirrors the YCbCr → RGB converter on the output side of the same datapath.
- Carries an end-of-line sideband bit in lockstep with pixel data; supports full backpressure.

---
 rtl/rgb_to_ycbcr_stream_if.sv | 22 ++
 rtl/rgb_to_ycbcr_stream.sv | 94 +++++++++
 2 files changed

// File: rtl/rgb_to_ycbcr_stream_if.sv
// rgb_to_ycbcr_stream_if: valid/ready pixel stream bundle for the RGB to YCbCr converter
// Signals:
//   i_valid/i_ready/i_r/i_g/i_b/i_last  RGB input stream (driven by master, ready from slave)
//   o_valid/o_ready/o_y/o_cb/o_cr/o_last YCbCr output stream (driven by slave, ready from master)
// Modports: slave = converter side, master = upstream/downstream environment side.
interface rgb_to_ycbcr_stream_if #(
    parameter int RGB_WIDTH   = 8,
    parameter int YCbCr_WIDTH = 8
);
    logic                   i_valid, i_ready, i_last;
    logic [RGB_WIDTH-1:0]   i_r, i_g, i_b;
    logic                   o_valid, o_ready, o_last;
    logic [YCbCr_WIDTH-1:0] o_y, o_cb, o_cr;
    modport slave (
        input  i_valid, i_r, i_g, i_b, i_last, o_ready,
        output i_ready, o_valid, o_y, o_cb, o_cr, o_last
    );
    modport master (
        output i_valid, i_r, i_g, i_b, i_last, o_ready,
        input  i_ready, o_valid, o_y, o_cb, o_cr, o_last
    );
endinterface

// File: rtl/rgb_to_ycbcr_stream.sv
// rgb_to_ycbcr_stream: 3-stage BT.601 studio-swing RGB to YCbCr converter with valid/ready handshake
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   s    rgb_to_ycbcr_stream_if.slave: RGB pixel in (i_*), YCbCr pixel out (o_*), end-of-line sideband
// Optional build macro: RGB2YCBCR_ROUND_EN adds round-half-up before the final shift.
module rgb_to_ycbcr_stream #(
    parameter int RGB_WIDTH   = 8,
    parameter int YCbCr_WIDTH = 8,
    parameter int COEF_FRAC   = 16
) (
    input logic                   clk,
    input logic                   rst,
    rgb_to_ycbcr_stream_if.slave  s
);
    localparam int W  = YCbCr_WIDTH;
    localparam int AW = W + COEF_FRAC + 4;
    typedef logic signed [AW-1:0] acc_t;

    // Q16 reference coefficients rescaled to COEF_FRAC with rounding
    function automatic acc_t coef(input int c);
        int k;
        if (COEF_FRAC >= 16) k = c <<< (COEF_FRAC - 16);
        else k = (c + (1 <<< (15 - COEF_FRAC))) >>> (16 - COEF_FRAC);
        return acc_t'(k);
    endfunction

    localparam acc_t K [9] = '{
        coef(16829),  coef(33039),  coef(6416),
        coef(-9714),  coef(-19070), coef(28784),
        coef(28784),  coef(-24103), coef(-4681)
    };
    localparam acc_t Y_OFF = acc_t'(16 << (W - 8)) <<< COEF_FRAC;
    localparam acc_t C_OFF = acc_t'(128 << (W - 8)) <<< COEF_FRAC;
`ifdef RGB2YCBCR_ROUND_EN
    localparam acc_t RND = acc_t'(1) <<< (COEF_FRAC - 1);
`else
    localparam acc_t RND = '0;
`endif

    logic         advance;
    logic [2:0]   v_q, l_q;
    acc_t         x [3];
    acc_t         prod_d [9], p_q [9];
    acc_t         sum_d [3], s_q [3];
    acc_t         sh [3];
    logic [W-1:0] sat_d [3];
    logic [W-1:0] y_q, cb_q, cr_q;

    // The whole pipeline moves as one unit, so only the last stage can stall it
    assign advance   = ~v_q[2] | s.o_ready;
    assign s.i_ready = advance;
    assign s.o_valid = v_q[2];
    assign s.o_last  = l_q[2];
    assign s.o_y     = y_q;
    assign s.o_cb    = cb_q;
    assign s.o_cr    = cr_q;

    always_comb begin
        x[0] = acc_t'(s.i_r);
        x[1] = acc_t'(s.i_g);
        x[2] = acc_t'(s.i_b);
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 3; k++) prod_d[3*c+k] = x[k] * K[3*c+k];
            sum_d[c] = p_q[3*c] + p_q[3*c+1] + p_q[3*c+2] + (c == 0 ? Y_OFF : C_OFF) + RND;
            sh[c]    = s_q[c] >>> COEF_FRAC;
            // Negative results clamp to 0, anything above W bits clamps to full scale
            sat_d[c] = sh[c][AW-1] ? '0 : (|sh[c][AW-2:W]) ? '1 : sh[c][W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            p_q <= prod_d;
            s_q <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q  <= '0;
            l_q  <= '0;
            y_q  <= '0;
            cb_q <= '0;
            cr_q <= '0;
        end else if (advance) begin
            v_q  <= {v_q[1:0], s.i_valid};
            l_q  <= {l_q[1:0] & v_q[1:0], s.i_valid & s.i_last};
            y_q  <= sat_d[0];
            cb_q <= sat_d[1];
            cr_q <= sat_d[2];
        end
    end
endmodule
